inst_mem_loader: RTL and testbench

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

---
 rtl/loader_pkg.sv | 18 +
 rtl/loader_timeout.sv | 28 ++
 rtl/inst_mem_loader.sv | 124 ++++++++++++
 tb/tb_inst_mem_loader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

  localparam int DEFAULT_DEPTH = 64;
  localparam int DEFAULT_AW = 6;
  localparam logic [7:0] CHECKSUM_OK = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERR
  } loader_state_t;

endpackage

// File: rtl/loader_timeout.sv
// Reloadable idle-cycle down-counter; expired pulses on the TIMEOUT-th consecutive idle tick.
module loader_timeout #(
  parameter int TIMEOUT = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(TIMEOUT);
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = tick && (cnt == CW'(1));

endmodule

// File: rtl/inst_mem_loader.sv
// Byte-stream loader: count byte, little-endian 32-bit words, checksum byte; writes
// instruction memory one word at a time and holds the CPU until a clean image is in.
module inst_mem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW = DEFAULT_AW,
  parameter int TIMEOUT = 100000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err,
  output loader_state_t dbg_state
);

  // Handshake: a byte transfers on a rising edge where byte_valid and byte_ready are both 1;
  // byte_data must be stable while byte_valid is high, and byte_ready never depends on byte_valid.

  localparam int NW = AW + 1;

  loader_state_t state, state_next;

  logic [AW-1:0] addr_q;
  logic [NW-1:0] n_words_q;
  logic [1:0]    byte_idx_q;
  logic [7:0]    sum_q;
  logic [31:0]   wdata_q;

  logic       hs;
  logic       start_ok;
  logic       last_word;
  logic       count_bad;
  logic [7:0] sum_next;
  logic       expired;

  assign hs        = byte_valid && byte_ready;
  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign last_word = ({1'b0, addr_q} == (n_words_q - NW'(1)));
  assign count_bad = (byte_data == 8'h00) || ({1'b0, byte_data} > 9'(DEPTH));
  assign sum_next  = sum_q + byte_data;

  loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (start_ok || hs),
    .tick    (byte_ready && !hs),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_next = S_COUNT;
      S_COUNT: begin
        if (hs) state_next = count_bad ? S_ERR : S_DATA;
        else if (expired) state_next = S_ERR;
      end
      S_DATA: begin
        if (hs && (byte_idx_q == 2'd3)) state_next = S_WRITE;
        else if (expired) state_next = S_ERR;
      end
      S_WRITE: state_next = last_word ? S_CHECK : S_DATA;
      S_CHECK: begin
        if (hs) state_next = (sum_next == CHECKSUM_OK) ? S_DONE : S_ERR;
        else if (expired) state_next = S_ERR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The address stops at the last word so it never wraps past DEPTH-1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q     <= '0;
      n_words_q  <= '0;
      byte_idx_q <= '0;
      sum_q      <= '0;
      wdata_q    <= '0;
    end else if (start_ok) begin
      addr_q     <= '0;
      n_words_q  <= '0;
      byte_idx_q <= '0;
      sum_q      <= '0;
      wdata_q    <= '0;
    end else begin
      if (hs) sum_q <= sum_next;
      if (hs && (state == S_COUNT)) n_words_q <= NW'(byte_data);
      if (hs && (state == S_DATA)) begin
        wdata_q[{byte_idx_q, 3'b000} +: 8] <= byte_data;
        byte_idx_q <= byte_idx_q + 2'd1;
      end
      if ((state == S_WRITE) && !last_word) addr_q <= addr_q + AW'(1);
    end
  end

  assign byte_ready = (state == S_COUNT) || (state == S_DATA) || (state == S_CHECK);
  assign busy       = byte_ready || (state == S_WRITE);
  assign cpu_hold   = busy || (state == S_ERR);
  assign done       = (state == S_DONE);
  assign err        = (state == S_ERR);
  assign mem_we     = (state == S_WRITE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized scoreboard bench for inst_mem_loader: drivers push expected writes and
// end-of-load status; a negedge monitor pops and compares whenever the DUT presents them.
module tb_inst_mem_loader;
  import loader_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW = 6;
  localparam int TIMEOUT = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic byte_ready, mem_we, cpu_hold, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  loader_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  logic [AW+31:0] exp_q[$];
  logic [2:0] res_q[$];
  logic [31:0] words_buf[DEPTH];
  logic prev_busy = 1'b0;

  inst_mem_loader #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {1'b1, mem_addr, mem_wdata}, 64'h0);
      end else begin
        chk("mem_write", {mem_addr, mem_wdata}, exp_q.pop_front());
      end
    end
    if (prev_busy && !busy) begin
      if (res_q.size() == 0) begin
        chk("unexpected_end", {done, err, cpu_hold}, 64'h7);
      end else begin
        chk("end_status{done,err,hold}", {done, err, cpu_hold}, res_q.pop_front());
      end
    end
    prev_busy = busy;
  end

  // ---------------- driver tasks ----------------
  task automatic gap(input int lo, input int hi);
    repeat ($urandom_range(hi, lo)) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    byte_valid = 1'b1;
    byte_data = b;
    @(negedge clk);
    while (!byte_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) begin
      chk("byte_accept_wait", 64'(byte_ready), 64'h1);
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("idle_wait", 64'(busy), 64'h0);
  endtask

  // Reference model: expected writes are simply (index, word) pairs; the checksum is the
  // byte that makes the mod-256 sum of the whole stream zero.
  task automatic load(input logic [7:0] cnt, input bit bad_ck, input int gap_lo, input int gap_hi,
                      input bit poke_start);
    logic [7:0] sum;
    logic [7:0] ck;
    int n;
    pulse_start();
    sum = cnt;
    if (cnt == 8'd0 || int'(cnt) > DEPTH) begin
      res_q.push_back(3'b011);
      gap(gap_lo, gap_hi);
      send_byte(cnt);
      wait_idle();
      return;
    end
    n = int'(cnt);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({AW'(i), words_buf[i]});
      for (int b = 0; b < 4; b++) sum = sum + words_buf[i][8*b +: 8];
    end
    ck = 8'd0 - sum;
    if (bad_ck) ck = ck + 8'd1;
    res_q.push_back(bad_ck ? 3'b011 : 3'b100);
    gap(gap_lo, gap_hi);
    send_byte(cnt);
    if (poke_start) pulse_start();
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++) begin
        gap(gap_lo, gap_hi);
        send_byte(words_buf[i][8*b +: 8]);
      end
    end
    gap(gap_lo, gap_hi);
    send_byte(ck);
    wait_idle();
  endtask

  task automatic randomize_words();
    for (int i = 0; i < DEPTH; i++) words_buf[i] = $urandom;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {byte_ready, mem_we, cpu_hold, busy, done, err}, 64'h0);
    chk("reset_addr_data", {mem_addr, mem_wdata}, 64'h0);
    chk("reset_state", 64'(dbg_state), 64'(S_IDLE));
    #1 rst = 1'b1;

    // Single-word image with good and then bad checksum.
    words_buf[0] = 32'h00100093;
    load(8'd1, 1'b0, 0, 0, 1'b0);
    chk("good_load_done_hold", {done, err, cpu_hold}, 64'h4);
    load(8'd1, 1'b1, 0, 1, 1'b0);
    chk("bad_ck_err_hold", {done, err, cpu_hold}, 64'h3);

    // Illegal counts.
    load(8'd0, 1'b0, 0, 1, 1'b0);
    load(8'd65, 1'b0, 0, 1, 1'b0);

    // Full memory with byte_valid toggling every other cycle.
    randomize_words();
    load(8'd64, 1'b0, 1, 1, 1'b0);

    // Stall after two data bytes until the idle timeout fires.
    pulse_start();
    res_q.push_back(3'b011);
    send_byte(8'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    for (int k = 0; k <= TIMEOUT; k++) begin
      @(negedge clk);
      if (k == TIMEOUT - 1) chk("timeout_not_yet", 64'(err), 64'h0);
      if (k == TIMEOUT) chk("timeout_err", 64'(err), 64'h1);
    end
    randomize_words();
    load(8'd3, 1'b0, 0, 2, 1'b0);

    // Reset in the middle of the second word.
    randomize_words();
    pulse_start();
    exp_q.push_back({AW'(0), words_buf[0]});
    res_q.push_back(3'b000);
    send_byte(8'd2);
    for (int b = 0; b < 4; b++) send_byte(words_buf[0][8*b +: 8]);
    send_byte(words_buf[1][7:0]);
    send_byte(words_buf[1][15:8]);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midload_reset_outputs", {byte_ready, mem_we, cpu_hold, busy, done, err}, 64'h0);
    chk("midload_reset_data", {mem_addr, mem_wdata}, 64'h0);

    // start pulsed while busy must be ignored.
    randomize_words();
    load(8'd2, 1'b0, 0, 1, 1'b1);

    // Random short loads.
    repeat (6) begin
      randomize_words();
      load(8'($urandom_range(8, 1)), 1'($urandom_range(1, 0)), 0, 2, 1'b0);
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("write_queue_drained", 64'(exp_q.size()), 64'h0);
    chk("status_queue_drained", 64'(res_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
